shift_arbiter: RTL and testbench
================================

// Module: shift_arbiter
// PURPOSE
//  Shares one 16-bit shifter datapath (rotl/shl/sra/srl) between NUM_REQ requesters.
//  Round-robin arbitration, valid/ready handshake on every port, one registered result stage.
//  Sits between the decode-side requesters (e.g. ALU shift path, address-gen path) and the shifter.
//  Instantiates the existing shifter; adds no shift logic of its own.
// PARAMETERS
//  NUM_REQ   2                      number of requesters; supported range 2..4
//  ID_W      (NUM_REQ>2) ? 2 : 1    width of out_id
// PORTS
//  clk        in   1            system clock, all state on posedge
//  rst        in   1            synchronous reset, active-high
//  req_valid  in   NUM_REQ      bit i: requester i presents a shift
//  req_ready  out  NUM_REQ      bit i: requester i accepted this cycle (one-hot or zero)
//  req_in     in   16*NUM_REQ   operand, requester i at [16*i+15:16*i]
//  req_cnt    in   4*NUM_REQ    shift count, requester i at [4*i+3:4*i]
//  req_op     in   2*NUM_REQ    00 rotl, 01 shl, 10 sra, 11 srl
//  out_valid  out  1            result register holds a valid result
//  out_ready  in   1            consumer takes the result this cycle
//  out_id     out  ID_W         index of the requester that owns out_data
//  out_data   out  16           shifted result
// BEHAVIOUR
//  Reset: out_valid=0, out_id=0, out_data=16'h0000, grant pointer ptr=NUM_REQ-1 (req 0 wins first).
//  req_ready is combinational and 0 while rst=1.
//  accept = !out_valid | out_ready; stage takes a new request only when accept=1.
//  Arbitration: search order ptr+1, ptr+2, ... mod NUM_REQ; first i with req_valid[i] wins.
//  req_ready[i] = accept & winner==i; at most one bit set; all 0 when no req_valid.
//  Handshake req_valid[i]&req_ready[i] -> next edge: out_valid=1, out_id=i,
//   out_data = shifter(req_in[i], req_cnt[i], req_op[i]); ptr=i.
//  Latency: exactly 1 cycle from handshake to out_valid. Throughput: 1 result/cycle while out_ready=1.
//  ptr changes only on a handshake; idle cycles leave it unchanged.
//  Backpressure: out_valid=1 & out_ready=0 -> out_data/out_id held stable, req_ready=0.
//  Simultaneous drain+fill: out_valid=1 & out_ready=1 & a winner exists -> new result loaded same edge.
//  Drain with no request: out_valid & out_ready & no req_valid -> out_valid=0; out_data holds last value.
//  Payload is sampled only at the handshake edge; a requester must hold valid+payload until ready.
//  Counts: cnt=0 passes req_in through for all ops; rotl wraps bit 15 into bit 0; sra replicates bit 15.
//  Reset mid-operation: pending result discarded (out_valid=0), ptr reset; no handshake completes in reset cycle.
//  NUM_REQ outside 2..4: elaboration error via generate-time check.
// CONFIGURATION
//  SHIFT_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins, ptr unused (held at reset value);
//   requester 0 can starve others by design.
//  Not defined (default): round-robin as above; with all requesters valid and out_ready=1,
//   grants rotate 0,1,..,NUM_REQ-1,0,... with no requester waiting more than NUM_REQ-1 grants.
// TESTING
//  Per op, req0 only: rotl 16'h8001 cnt1 -> 16'h0003; shl 16'h0001 cnt4 -> 16'h0010;
//   sra 16'h8000 cnt15 -> 16'hFFFF; srl 16'h8000 cnt15 -> 16'h0001; each out_id=0, 1 cycle after handshake.
//  cnt=0 all ops on 16'hA5C3 -> 16'hA5C3 each time.
//  NUM_REQ=2, both valid continuously, out_ready=1: grants alternate 0,1,0,1; out_id follows, one result/cycle.
//  out_ready=0 for 3 cycles with out_valid=1: out_data/out_id constant, req_ready=0; release -> next grant same cycle.
//  rst asserted while out_valid=1 and req1 valid: next cycle out_valid=0, req_ready=0; first grant after reset to req0.
//  With SHIFT_ARB_FIXED_PRIO_EN, both valid, out_ready=1 for 4 cycles: out_id=0 every cycle, req_ready[1]=0 throughout.

Source files
------------

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin (or fixed-priority with SHIFT_ARB_FIXED_PRIO_EN) sharing of one
// 16-bit shifter between NUM_REQ valid/ready requesters, with a single registered result stage.
`default_nettype none

// ============================================================================
//  Module   : shift_arbiter_shifter
//  Purpose  : 16-bit rotl/shl/sra/srl shifter datapath (combinational)
//  Revision : 1.0
// ============================================================================
module shift_arbiter_shifter (
  input  logic [15:0] data_i,
  input  logic [3:0]  cnt_i,
  input  logic [1:0]  op_i,
  output logic [15:0] data_o
);

  logic [31:0] dbl;

  always_comb begin
    // Rotate-left is the upper half of the operand shifted as a doubled word.
    dbl = {data_i, data_i} << cnt_i;
    unique case (op_i)
      2'b00:   data_o = dbl[31:16];
      2'b01:   data_o = data_i << cnt_i;
      2'b10:   data_o = $signed(data_i) >>> cnt_i;
      default: data_o = data_i >> cnt_i;
    endcase
  end

endmodule

// ============================================================================
//  Module   : shift_arbiter
//  Purpose  : Arbitrates NUM_REQ requesters onto the shared shifter, one
//             registered result stage. Optional macro: SHIFT_ARB_FIXED_PRIO_EN
//  Revision : 1.0
// ============================================================================
module shift_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 2) ? 2 : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [16*NUM_REQ-1:0] req_in,
  input  logic [4*NUM_REQ-1:0]  req_cnt,
  input  logic [2*NUM_REQ-1:0]  req_op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ID_W-1:0]       out_id,
  output logic [15:0]           out_data
);

  if ((NUM_REQ < 2) || (NUM_REQ > 4)) begin : g_bad_num_req
    $error("shift_arbiter: NUM_REQ must be in 2..4");
  end

  logic              out_valid_q, out_valid_d;
  logic [ID_W-1:0]   out_id_q,    out_id_d;
  logic [15:0]       out_data_q,  out_data_d;
  logic [ID_W-1:0]   winner;
  logic              found;
  logic              accept;
  logic              handshake;
  logic [15:0]       shift_res;

`ifdef SHIFT_ARB_FIXED_PRIO_EN
  // Descending scan so the lowest valid index is the last one written.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        found  = 1'b1;
        winner = ID_W'(i);
      end
    end
  end
`else
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] cand;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((32'(ptr_q) + 32'(k)) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign ptr_d = handshake ? winner : ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= ID_W'(NUM_REQ - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  assign accept    = !out_valid_q || out_ready;
  assign handshake = accept && found && !rst;
  assign req_ready = handshake ? (NUM_REQ'(1) << winner) : '0;

  shift_arbiter_shifter u_shifter (
    .data_i (req_in[16*winner +: 16]),
    .cnt_i  (req_cnt[4*winner +: 4]),
    .op_i   (req_op[2*winner +: 2]),
    .data_o (shift_res)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    out_data_d  = out_data_q;
    if (handshake) begin
      out_valid_d = 1'b1;
      out_id_d    = winner;
      out_data_d  = shift_res;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_data_q  <= 16'h0000;
    end else begin
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign out_data  = out_data_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: table-driven directed checks of shift_arbiter with NUM_REQ=2, plus
// hand-written backpressure and reset-mid-operation sequences.
`default_nettype none

// ============================================================================
//  Module   : tb_shift_arbiter
//  Purpose  : Self-checking bench for shift_arbiter (NUM_REQ=2)
//  Revision : 1.0
// ============================================================================
module tb_shift_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;
  localparam int NVEC    = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [16*NUM_REQ-1:0] req_in;
  logic [4*NUM_REQ-1:0]  req_cnt;
  logic [2*NUM_REQ-1:0]  req_op;
  logic                  out_valid;
  logic                  out_ready;
  logic [ID_W-1:0]       out_id;
  logic [15:0]           out_data;

  int checks = 0;
  int errors = 0;

  shift_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_in    (req_in),
    .req_cnt   (req_cnt),
    .req_op    (req_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_id    (out_id),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  valid;
    logic [15:0] in0, in1;
    logic [3:0]  cnt0, cnt1;
    logic [1:0]  op0, op1;
    logic [1:0]  exp_ready;
    logic        exp_valid;
    logic        exp_id;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [15:0] i0, input logic [15:0] i1,
                       input logic [3:0] c0, input logic [3:0] c1,
                       input logic [1:0] o0, input logic [1:0] o1);
    req_valid = v;
    req_in    = {i1, i0};
    req_cnt   = {c1, c0};
    req_op    = {o1, o0};
  endtask

  function automatic vec_t mk(input logic [1:0] v, input logic [15:0] i0, input logic [15:0] i1,
                              input logic [3:0] c0, input logic [3:0] c1,
                              input logic [1:0] o0, input logic [1:0] o1,
                              input logic [1:0] er, input logic ev, input logic eid,
                              input logic [15:0] ed);
    vec_t t;
    t.valid = v; t.in0 = i0; t.in1 = i1; t.cnt0 = c0; t.cnt1 = c1; t.op0 = o0; t.op1 = o1;
    t.exp_ready = er; t.exp_valid = ev; t.exp_id = eid; t.exp_data = ed;
    return t;
  endfunction

  initial begin
    // Per-op, cnt=0 passthrough, idle drain, then both-valid rotation.
    vecs[0]  = mk(2'b01, 16'h8001, 16'h0000, 4'd1,  4'd0, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0, 16'h0003);
    vecs[1]  = mk(2'b01, 16'h0001, 16'h0000, 4'd4,  4'd0, 2'b01, 2'b00, 2'b01, 1'b1, 1'b0, 16'h0010);
    vecs[2]  = mk(2'b01, 16'h8000, 16'h0000, 4'd15, 4'd0, 2'b10, 2'b00, 2'b01, 1'b1, 1'b0, 16'hFFFF);
    vecs[3]  = mk(2'b01, 16'h8000, 16'h0000, 4'd15, 4'd0, 2'b11, 2'b00, 2'b01, 1'b1, 1'b0, 16'h0001);
    vecs[4]  = mk(2'b01, 16'hA5C3, 16'h0000, 4'd0,  4'd0, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0, 16'hA5C3);
    vecs[5]  = mk(2'b01, 16'hA5C3, 16'h0000, 4'd0,  4'd0, 2'b01, 2'b00, 2'b01, 1'b1, 1'b0, 16'hA5C3);
    vecs[6]  = mk(2'b01, 16'hA5C3, 16'h0000, 4'd0,  4'd0, 2'b10, 2'b00, 2'b01, 1'b1, 1'b0, 16'hA5C3);
    vecs[7]  = mk(2'b01, 16'hA5C3, 16'h0000, 4'd0,  4'd0, 2'b11, 2'b00, 2'b01, 1'b1, 1'b0, 16'hA5C3);
    vecs[8]  = mk(2'b00, 16'h0000, 16'h0000, 4'd0,  4'd0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 16'hA5C3);
    vecs[9]  = mk(2'b10, 16'h0000, 16'h1234, 4'd0,  4'd4, 2'b00, 2'b00, 2'b10, 1'b1, 1'b1, 16'h2341);
    vecs[10] = mk(2'b11, 16'h00F0, 16'hF000, 4'd4,  4'd4, 2'b01, 2'b10, 2'b01, 1'b1, 1'b0, 16'h0F00);
`ifdef SHIFT_ARB_FIXED_PRIO_EN
    vecs[11] = mk(2'b11, 16'h00F0, 16'hF000, 4'd4,  4'd4, 2'b01, 2'b10, 2'b01, 1'b1, 1'b0, 16'h0F00);
    vecs[13] = mk(2'b11, 16'h00F0, 16'hF000, 4'd4,  4'd4, 2'b01, 2'b10, 2'b01, 1'b1, 1'b0, 16'h0F00);
`else
    vecs[11] = mk(2'b11, 16'h00F0, 16'hF000, 4'd4,  4'd4, 2'b01, 2'b10, 2'b10, 1'b1, 1'b1, 16'hFF00);
    vecs[13] = mk(2'b11, 16'h00F0, 16'hF000, 4'd4,  4'd4, 2'b01, 2'b10, 2'b10, 1'b1, 1'b1, 16'hFF00);
`endif
    vecs[12] = mk(2'b11, 16'h00F0, 16'hF000, 4'd4,  4'd4, 2'b01, 2'b10, 2'b01, 1'b1, 1'b0, 16'h0F00);
    vecs[14] = mk(2'b10, 16'h0000, 16'h8001, 4'd0,  4'd1, 2'b00, 2'b11, 2'b10, 1'b1, 1'b1, 16'h4000);
    vecs[15] = mk(2'b00, 16'h0000, 16'h0000, 4'd0,  4'd0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 16'h4000);

    // Reset with requests pending: no grant, outputs cleared.
    rst       = 1'b1;
    out_ready = 1'b1;
    drive(2'b11, 16'h1111, 16'h2222, 4'd1, 4'd1, 2'b01, 2'b01);
    @(negedge clk);
    check("rst_req_ready", 16'(req_ready), 16'h0);
    @(posedge clk); #1;
    check("rst_out_valid", 16'(out_valid), 16'h0);
    check("rst_out_id",    16'(out_id),    16'h0);
    check("rst_out_data",  out_data,       16'h0000);

    @(negedge clk);
    rst = 1'b0;
    drive(2'b00, 16'h0, 16'h0, 4'd0, 4'd0, 2'b00, 2'b00);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i].valid, vecs[i].in0, vecs[i].in1, vecs[i].cnt0, vecs[i].cnt1,
            vecs[i].op0, vecs[i].op1);
      #1;
      check($sformatf("vec%0d_req_ready", i), 16'(req_ready), 16'(vecs[i].exp_ready));
      @(posedge clk); #1;
      check($sformatf("vec%0d_out_valid", i), 16'(out_valid), 16'(vecs[i].exp_valid));
      check($sformatf("vec%0d_out_id", i),    16'(out_id),    16'(vecs[i].exp_id));
      check($sformatf("vec%0d_out_data", i),  out_data,       vecs[i].exp_data);
    end

    // Backpressure: hold result for 3 cycles with both requesters waiting.
    @(negedge clk);
    drive(2'b01, 16'h0003, 16'h0000, 4'd1, 4'd0, 2'b01, 2'b00);
    @(posedge clk); #1;
    check("bp_load_data", out_data, 16'h0006);
    @(negedge clk);
    out_ready = 1'b0;
    drive(2'b11, 16'h00F0, 16'hF000, 4'd4, 4'd4, 2'b01, 2'b10);
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("bp%0d_req_ready", c), 16'(req_ready), 16'h0);
      @(posedge clk); #1;
      check($sformatf("bp%0d_out_valid", c), 16'(out_valid), 16'h1);
      check($sformatf("bp%0d_out_id", c),    16'(out_id),    16'h0);
      check($sformatf("bp%0d_out_data", c),  out_data,       16'h0006);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
`ifdef SHIFT_ARB_FIXED_PRIO_EN
    check("bp_release_ready", 16'(req_ready), 16'h1);
    @(posedge clk); #1;
    check("bp_release_id",   16'(out_id), 16'h0);
    check("bp_release_data", out_data,    16'h0F00);
`else
    check("bp_release_ready", 16'(req_ready), 16'h2);
    @(posedge clk); #1;
    check("bp_release_id",   16'(out_id), 16'h1);
    check("bp_release_data", out_data,    16'hFF00);
`endif

    // Reset mid-operation with a valid result and req1 pending.
    @(negedge clk);
    rst       = 1'b1;
    out_ready = 1'b0;
    drive(2'b10, 16'h0000, 16'hF000, 4'd0, 4'd4, 2'b00, 2'b10);
    #1;
    check("midrst_req_ready", 16'(req_ready), 16'h0);
    @(posedge clk); #1;
    check("midrst_out_valid", 16'(out_valid), 16'h0);
    check("midrst_out_data",  out_data,       16'h0000);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    drive(2'b11, 16'h00F0, 16'hF000, 4'd4, 4'd4, 2'b01, 2'b10);
    #1;
    check("postrst_req_ready", 16'(req_ready), 16'h1);
    @(posedge clk); #1;
    check("postrst_out_id",    16'(out_id),    16'h0);
    check("postrst_out_valid", 16'(out_valid), 16'h1);

    // Both valid, free-running: fixed priority always picks 0, round-robin alternates.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
`ifdef SHIFT_ARB_FIXED_PRIO_EN
      check($sformatf("run%0d_req_ready", c), 16'(req_ready), 16'h1);
      @(posedge clk); #1;
      check($sformatf("run%0d_out_id", c), 16'(out_id), 16'h0);
`else
      check($sformatf("run%0d_req_ready", c), 16'(req_ready), (c % 2 == 0) ? 16'h2 : 16'h1);
      @(posedge clk); #1;
      check($sformatf("run%0d_out_id", c), 16'(out_id), (c % 2 == 0) ? 16'h1 : 16'h0);
`endif
      check($sformatf("run%0d_out_valid", c), 16'(out_valid), 16'h1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
